// File: rtl/hash_result_scanner.sv
// Reads back NUM_NONCES SHA-256 digests written by the nonce hasher, compares each
// against a difficulty target, and reports the lowest winning nonce and the minimum digest.
module hash_result_scanner #(
    parameter int NUM_NONCES  = 16,
    parameter int WORD_STRIDE = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  base_addr,
    input  logic [255:0] target,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic         done,
    output logic         found,
    output logic [7:0]   found_nonce,
    output logic [7:0]   best_nonce,
    output logic [255:0] best_hash
);

    typedef enum logic [1:0] {IDLE, READ, CMP} state_t;

    localparam logic [15:0] STRIDE     = 16'(WORD_STRIDE);
    localparam logic [7:0]  LAST_NONCE = 8'(NUM_NONCES - 1);

    state_t        state;
    logic [7:0]    nonce;
    logic [15:0]   nonce_addr;
    logic [3:0]    phase;
    logic [255:0]  target_lat;
    logic [31:0]   h_p2 [0:7];
    logic [2:0]    slot;
    logic [255:0]  digest;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    // phase counts edges since the word-0 issue; word (phase-2) lands on this edge
    assign slot   = phase[2:0] - 3'd2;
    assign digest = {h_p2[0], h_p2[1], h_p2[2], h_p2[3],
                     h_p2[4], h_p2[5], h_p2[6], h_p2[7]};

    // ---- stage p2: read data capture (data path, no reset) ----
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            target_lat <= target;
        end
        if (state == READ && phase >= 4'd2) begin
            h_p2[slot] <= mem_read_data;
        end
    end

    // ---- control: address issue, compare and result registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            done        <= 1'b1;
            mem_addr    <= 16'd0;
            found       <= 1'b0;
            found_nonce <= 8'd0;
            best_nonce  <= 8'd0;
            best_hash   <= '1;
            nonce       <= 8'd0;
            nonce_addr  <= 16'd0;
            phase       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        found       <= 1'b0;
                        found_nonce <= 8'd0;
                        best_nonce  <= 8'd0;
                        best_hash   <= '1;
                        nonce       <= 8'd0;
                        nonce_addr  <= base_addr;
                        mem_addr    <= base_addr;
                        phase       <= 4'd1;
                        done        <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (phase <= 4'd7) begin
                        mem_addr <= mem_addr + STRIDE;
                    end
                    if (phase == 4'd9) begin
                        state <= CMP;
                    end
                    phase <= phase + 4'd1;
                end
                CMP: begin
                    if (digest < target_lat && !found) begin
                        found       <= 1'b1;
                        found_nonce <= nonce;
                    end
                    // strict compare keeps the earlier nonce on ties
                    if (digest < best_hash) begin
                        best_hash  <= digest;
                        best_nonce <= nonce;
                    end
                    if (nonce == LAST_NONCE) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        nonce      <= nonce + 8'd1;
                        nonce_addr <= nonce_addr + 16'd1;
                        mem_addr   <= nonce_addr + 16'd1;
                        phase      <= 4'd1;
                        state      <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_result_scanner.sv
// Self-checking bench for hash_result_scanner: a 2-edge-latency memory model plus a
// reference that scans digests with plain loops (minimum, first index below target).
module tb_hash_result_scanner;

    localparam int N = 16;
    localparam int S = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  base_addr;
    logic [255:0] target;
    logic         mem_clk;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_read_data;
    logic         done;
    logic         found;
    logic [7:0]   found_nonce;
    logic [7:0]   best_nonce;
    logic [255:0] best_hash;

    logic [31:0]  mem [0:65535];

    int total  = 0;
    int passed = 0;

    logic         ef;
    logic [7:0]   efn, ebn;
    logic [255:0] ebh;

    hash_result_scanner #(.NUM_NONCES(N), .WORD_STRIDE(S)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .target(target),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr), .mem_read_data(mem_read_data),
        .done(done), .found(found), .found_nonce(found_nonce), .best_nonce(best_nonce),
        .best_hash(best_hash)
    );

    always #5 clk = ~clk;

    // registered read: address set at edge k is read at k+1, seen by the DUT at k+2
    always @(posedge clk) mem_read_data <= mem[mem_addr];

    function automatic logic [15:0] waddr(input logic [15:0] base, input int n, input int w);
        return 16'(int'(base) + n + w * S);
    endfunction

    function automatic logic [255:0] digest_of(input logic [15:0] base, input int n);
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[255 - 32*w -: 32] = mem[waddr(base, n, w)];
        return d;
    endfunction

    task automatic set_digest(input logic [15:0] base, input int n, input logic [255:0] d);
        for (int w = 0; w < 8; w++) mem[waddr(base, n, w)] = d[255 - 32*w -: 32];
    endtask

    task automatic fill_random(input logic [15:0] base);
        for (int n = 0; n < N; n++) begin
            for (int w = 0; w < 8; w++) mem[waddr(base, n, w)] = $urandom;
            if ($urandom_range(0, 2) == 0) mem[waddr(base, n, 0)] = $urandom_range(0, 255);
        end
        // plant a duplicate so ties appear regularly
        set_digest(base, $urandom_range(8, N-1), digest_of(base, $urandom_range(0, 7)));
    endtask

    task automatic ref_model(input logic [15:0] base, input logic [255:0] tgt);
        logic [255:0] d [N];
        logic [255:0] mn;
        for (int n = 0; n < N; n++) d[n] = digest_of(base, n);
        mn = d[0];
        for (int n = 1; n < N; n++) if (d[n] < mn) mn = d[n];
        ebh = mn;
        ebn = 8'd0;
        for (int n = N-1; n >= 0; n--) if (d[n] == mn) ebn = 8'(n);
        ef  = 1'b0;
        efn = 8'd0;
        for (int n = N-1; n >= 0; n--) if (d[n] < tgt) begin ef = 1'b1; efn = 8'(n); end
    endtask

    task automatic start_scan(input logic [15:0] base, input logic [255:0] tgt);
        @(negedge clk);
        base_addr = base;
        target    = tgt;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int edges);
        edges = from;
        while (done !== 1'b1 && edges < 2000) begin
            @(posedge clk);
            #1 edges++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; base_addr = '0; target = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (done !== 1'b1) $display("FAIL rst_done: got %b want 1", done); else passed++;
        total++; if (mem_addr !== 16'd0) $display("FAIL rst_addr: got %h want 0000", mem_addr); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we); else passed++;
        total++; if (mem_clk !== clk) $display("FAIL rst_memclk: got %b want %b", mem_clk, clk); else passed++;
        total++; if (found !== 1'b0) $display("FAIL rst_found: got %b want 0", found); else passed++;
        total++; if (found_nonce !== 8'd0) $display("FAIL rst_fnonce: got %0d want 0", found_nonce); else passed++;
        total++; if (best_nonce !== 8'd0) $display("FAIL rst_bnonce: got %0d want 0", best_nonce); else passed++;
        total++; if (best_hash !== '1) $display("FAIL rst_bhash: got %h want all ones", best_hash); else passed++;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_address;
        logic [15:0]  base = 16'h0100;
        logic [255:0] tgt;
        logic [15:0]  exp;
        int n, w;
        fill_random(base);
        tgt = digest_of(base, $urandom_range(0, N-1));
        ref_model(base, tgt);
        start_scan(base, tgt);
        for (int e = 0; e <= 160; e++) begin
            if (e == 160) begin n = N - 1; w = 7; end
            else begin n = e / 10; w = (e % 10 > 7) ? 7 : e % 10; end
            exp = waddr(base, n, w);
            total++; if (mem_addr !== exp) $display("FAIL addr_seq e%0d: got %h want %h", e, mem_addr, exp); else passed++;
            total++; if (mem_we !== 1'b0) $display("FAIL addr_we e%0d: got %b want 0", e, mem_we); else passed++;
            total++; if (done !== (e == 160)) $display("FAIL addr_done e%0d: got %b want %b", e, done, e == 160); else passed++;
            if (e < 160) begin @(posedge clk); #1; end
        end
        total++; if (found !== ef) $display("FAIL addr_found: got %b want %b", found, ef); else passed++;
        total++; if (found_nonce !== efn) $display("FAIL addr_fnonce: got %0d want %0d", found_nonce, efn); else passed++;
        total++; if (best_nonce !== ebn) $display("FAIL addr_bnonce: got %0d want %0d", best_nonce, ebn); else passed++;
        total++; if (best_hash !== ebh) $display("FAIL addr_bhash: got %h want %h", best_hash, ebh); else passed++;
    endtask

    task automatic test_hit_best;
        logic [15:0]  base = 16'h2000;
        logic [255:0] tgt = {32'h0000_0FC0, 224'h0};
        int edges;
        for (int n = 0; n < N; n++) set_digest(base, n, {32'h0000_1000 - 32'(n * 16), 224'h0});
        ref_model(base, tgt);
        start_scan(base, tgt);
        wait_done(0, edges);
        // nonce 4 equals the target exactly, so the first strict hit is nonce 5
        total++; if (edges !== 160) $display("FAIL hit_latency: got %0d want 160", edges); else passed++;
        total++; if (found !== 1'b1) $display("FAIL hit_found: got %b want 1", found); else passed++;
        total++; if (found_nonce !== efn) $display("FAIL hit_fnonce: got %0d want %0d", found_nonce, efn); else passed++;
        total++; if (best_nonce !== 8'd15) $display("FAIL hit_bnonce: got %0d want 15", best_nonce); else passed++;
        total++; if (best_hash !== {32'h0000_0F10, 224'h0}) $display("FAIL hit_bhash: got %h want 0f10..", best_hash); else passed++;
    endtask

    task automatic test_no_hit;
        logic [15:0] base = 16'h3000;
        int edges;
        for (int n = 0; n < N; n++) set_digest(base, n, '1);
        start_scan(base, '1);
        wait_done(0, edges);
        total++; if (edges !== 160) $display("FAIL nohit_latency: got %0d want 160", edges); else passed++;
        total++; if (found !== 1'b0) $display("FAIL nohit_found: got %b want 0", found); else passed++;
        total++; if (found_nonce !== 8'd0) $display("FAIL nohit_fnonce: got %0d want 0", found_nonce); else passed++;
        total++; if (best_nonce !== 8'd0) $display("FAIL nohit_bnonce: got %0d want 0", best_nonce); else passed++;
        total++; if (best_hash !== '1) $display("FAIL nohit_bhash: got %h want all ones", best_hash); else passed++;
    endtask

    task automatic test_tie;
        logic [15:0]  base = 16'h4000;
        logic [255:0] low5 = {224'h0, 32'h5};
        int edges;
        for (int n = 0; n < N; n++) set_digest(base, n, (n == 3 || n == 9) ? low5 : '1);
        start_scan(base, low5);
        wait_done(0, edges);
        total++; if (found !== 1'b0) $display("FAIL tie_found: got %b want 0", found); else passed++;
        total++; if (best_nonce !== 8'd3) $display("FAIL tie_bnonce: got %0d want 3", best_nonce); else passed++;
        total++; if (best_hash !== low5) $display("FAIL tie_bhash: got %h want %h", best_hash, low5); else passed++;
    endtask

    task automatic test_busy_start;
        logic [15:0]  base = 16'h0500;
        logic [255:0] tgt = {32'h0000_0080, 224'h0};
        int edges;
        fill_random(base);
        fill_random(16'h0600);
        ref_model(base, tgt);
        start_scan(base, tgt);
        repeat (49) @(posedge clk);
        @(negedge clk);
        base_addr = 16'h0600; target = '0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(50, edges);
        total++; if (edges !== 160) $display("FAIL busy_latency: got %0d want 160", edges); else passed++;
        total++; if (found !== ef) $display("FAIL busy_found: got %b want %b", found, ef); else passed++;
        total++; if (found_nonce !== efn) $display("FAIL busy_fnonce: got %0d want %0d", found_nonce, efn); else passed++;
        total++; if (best_nonce !== ebn) $display("FAIL busy_bnonce: got %0d want %0d", best_nonce, ebn); else passed++;
        total++; if (best_hash !== ebh) $display("FAIL busy_bhash: got %h want %h", best_hash, ebh); else passed++;
    endtask

    task automatic test_wrap;
        logic [15:0]  base = 16'hFFF8;
        logic [255:0] tgt;
        int edges;
        fill_random(base);
        tgt = digest_of(base, $urandom_range(0, N-1));
        ref_model(base, tgt);
        start_scan(base, tgt);
        total++; if (mem_addr !== 16'hFFF8) $display("FAIL wrap_w0: got %h want fff8", mem_addr); else passed++;
        @(posedge clk);
        #1;
        total++; if (mem_addr !== 16'h0008) $display("FAIL wrap_w1: got %h want 0008", mem_addr); else passed++;
        wait_done(1, edges);
        total++; if (edges !== 160) $display("FAIL wrap_latency: got %0d want 160", edges); else passed++;
        total++; if (found !== ef) $display("FAIL wrap_found: got %b want %b", found, ef); else passed++;
        total++; if (found_nonce !== efn) $display("FAIL wrap_fnonce: got %0d want %0d", found_nonce, efn); else passed++;
        total++; if (best_nonce !== ebn) $display("FAIL wrap_bnonce: got %0d want %0d", best_nonce, ebn); else passed++;
        total++; if (best_hash !== ebh) $display("FAIL wrap_bhash: got %h want %h", best_hash, ebh); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [15:0] base = 16'h0700;
        fill_random(base);
        start_scan(base, '1);
        repeat (37) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (done !== 1'b1) $display("FAIL mid_done: got %b want 1", done); else passed++;
        total++; if (mem_addr !== 16'd0) $display("FAIL mid_addr: got %h want 0000", mem_addr); else passed++;
        total++; if (found !== 1'b0) $display("FAIL mid_found: got %b want 0", found); else passed++;
        total++; if (best_hash !== '1) $display("FAIL mid_bhash: got %h want all ones", best_hash); else passed++;
        total++; if (best_nonce !== 8'd0) $display("FAIL mid_bnonce: got %0d want 0", best_nonce); else passed++;
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            total++; if (mem_addr !== 16'd0 || done !== 1'b1) $display("FAIL mid_idle c%0d: got addr %h done %b want 0000/1", i, mem_addr, done); else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0]  base;
        logic [255:0] tgt;
        int edges;
        for (int r = 0; r < 4; r++) begin
            base = 16'($urandom);
            fill_random(base);
            if (r[0]) tgt = digest_of(base, $urandom_range(0, N-1));
            else tgt = {32'($urandom_range(0, 300)), 224'($urandom)};
            ref_model(base, tgt);
            start_scan(base, tgt);
            wait_done(0, edges);
            total++; if (edges !== 160) $display("FAIL b2b%0d_latency: got %0d want 160", r, edges); else passed++;
            total++; if (found !== ef) $display("FAIL b2b%0d_found: got %b want %b", r, found, ef); else passed++;
            total++; if (found_nonce !== efn) $display("FAIL b2b%0d_fnonce: got %0d want %0d", r, found_nonce, efn); else passed++;
            total++; if (best_nonce !== ebn) $display("FAIL b2b%0d_bnonce: got %0d want %0d", r, best_nonce, ebn); else passed++;
            total++; if (best_hash !== ebh) $display("FAIL b2b%0d_bhash: got %h want %h", r, best_hash, ebh); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_address;
        test_hit_best;
        test_no_hit;
        test_tie;
        test_busy_start;
        test_wrap;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
